fifo_stream_rx_bridge: RTL and testbench

//  Receiving end of the DMA fifo_stream conduit (256-bit data/write/send).

---
 rtl/fifo_stream_rx_bridge.sv | 138 +++++++++++++
 tb/tb_fifo_stream_rx_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_rx_bridge.sv
// fifo_stream_rx_bridge
// Receives 256-bit words from the DMA fifo_stream conduit and presents them
// as a 64-bit show-ahead read port (lane 0 = bits [63:0] first). Each entry
// carries a last-word tag taken from send. pkt_done pulses when the final
// lane of a tagged entry is consumed. overflow latches when a write is
// dropped because the buffer was full.
module fifo_stream_rx_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [255:0]          fifo_stream_fifo_data,
  input  logic                  fifo_stream_fifo_write,
  input  logic                  fifo_stream_fifo_send,
  output logic [63:0]           from_fifo_fifo_data,
  input  logic                  from_fifo_fifo_read,
  output logic                  from_fifo_fifo_empty,
  output logic                  from_fifo_fifo_full,
  output logic                  pkt_done,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Entry storage: word plus last-word tag
  logic [255:0]          mem_data [DEPTH];
  logic                  mem_last [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic [1:0]            lane;
  logic [1:0]            lane_next;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  full_q;
  logic                  vld_p1;
  logic                  vld_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  pop;
  logic [255:0]          head_next;
  logic [63:0]           data_p1;
  logic                  pkt_done_q;
  logic                  overflow_q;

  // Extract one 64-bit lane of a 256-bit word
  function automatic logic [63:0] lane_sel(input logic [255:0] w, input logic [1:0] l);
    logic [63:0] r;
    case (l)
      2'd0:    r = w[63:0];
      2'd1:    r = w[127:64];
      2'd2:    r = w[191:128];
      default: r = w[255:192];
    endcase
    return r;
  endfunction

  // Next-state decode for pointers, lane, level and the visible-valid flag.
  // Reads qualify on the registered valid flag, so an entry is not readable
  // until the cycle after it is stored; the same flag drops immediately when
  // the last entry is popped. A write whose slot becomes the new head in the
  // same edge is forwarded directly so the data register never sees stale RAM.
  always_comb begin
    wr_acc      = fifo_stream_fifo_write && !full_q;
    rd_acc      = from_fifo_fifo_read && vld_p1;
    pop         = rd_acc && (lane == 2'd3);
    lane_next   = rd_acc ? lane + 2'd1 : lane;
    rd_ptr_next = pop ? rd_ptr + PTR_ONE : rd_ptr;
    level_next  = level_q;
    if (wr_acc && !pop) begin
      level_next = level_q + LEVEL_ONE;
    end else if (!wr_acc && pop) begin
      level_next = level_q - LEVEL_ONE;
    end
    vld_next  = (level_next != '0) && (level_q != '0);
    head_next = mem_data[rd_ptr_next];
    if (wr_acc && (wr_ptr == rd_ptr_next)) begin
      head_next = fifo_stream_fifo_data;
    end
  end

  // Stage p0 -> storage: accepted words and their tags (no reset on data)
  always_ff @(posedge clk_clk) begin
    if (wr_acc) begin
      mem_data[wr_ptr] <= fifo_stream_fifo_data;
      mem_last[wr_ptr] <= fifo_stream_fifo_send;
    end
  end

  // Control state: pointers, lane, level, flags, packet pulse, sticky overflow
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lane       <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      vld_p1     <= 1'b0;
      pkt_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr     <= rd_ptr_next;
      lane       <= lane_next;
      level_q    <= level_next;
      full_q     <= (level_next == LEVEL_FULL);
      vld_p1     <= vld_next;
      pkt_done_q <= pop && mem_last[rd_ptr];
      if (fifo_stream_fifo_write && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Stage p1: registered head lane; holds its value while nothing is readable
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      data_p1 <= '0;
    end else if (vld_next) begin
      data_p1 <= lane_sel(head_next, lane_next);
    end
  end

  assign from_fifo_fifo_data  = data_p1;
  assign from_fifo_fifo_empty = !vld_p1;
  assign from_fifo_fifo_full  = full_q;
  assign pkt_done             = pkt_done_q;
  assign overflow             = overflow_q;
  assign level                = level_q;

endmodule

// File: tb/tb_fifo_stream_rx_bridge.sv
// Directed testbench for fifo_stream_rx_bridge (DEPTH_LOG2 = 4).
// Inputs change 1ns after the rising edge; outputs are sampled at that point.
module tb_fifo_stream_rx_bridge;

  logic         clk;
  logic         rst_n;
  logic [255:0] wdata;
  logic         write;
  logic         send;
  logic [63:0]  rdata;
  logic         read;
  logic         empty;
  logic         full;
  logic         pkt_done;
  logic         overflow;
  logic [4:0]   level;

  int checks;
  int failures;

  fifo_stream_rx_bridge #(.DEPTH_LOG2(4)) dut (
    .clk_clk                (clk),
    .reset_reset_n          (rst_n),
    .fifo_stream_fifo_data  (wdata),
    .fifo_stream_fifo_write (write),
    .fifo_stream_fifo_send  (send),
    .from_fifo_fifo_data    (rdata),
    .from_fifo_fifo_read    (read),
    .from_fifo_fifo_empty   (empty),
    .from_fifo_fifo_full    (full),
    .pkt_done               (pkt_done),
    .overflow               (overflow),
    .level                  (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane j of test word k carries k*16 + j + 1
  function automatic logic [63:0] lane_of(input int k, input int j);
    return 64'(k * 16 + j + 1);
  endfunction

  function automatic logic [255:0] word_of(input int k);
    logic [255:0] w;
    for (int j = 0; j < 4; j++) w[64*j +: 64] = lane_of(k, j);
    return w;
  endfunction

  task automatic do_reset();
    write = 1'b0; send = 1'b0; read = 1'b0; wdata = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill16();
    for (int k = 0; k < 16; k++) begin
      write = 1'b1; send = 1'b0; wdata = word_of(k);
      tick();
    end
    write = 1'b0;
  endtask

  logic [63:0] q[$];
  int widx;
  int exp_pkts;
  int got_pkts;
  bit saw_full;
  logic [63:0] hold;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1; write = 1'b0; send = 1'b0; read = 1'b0; wdata = '0;

    // 1: reset state, single tagged word, four lanes, pkt_done
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_data", rdata, 64'h0);
    chk("rst_level", level, 5'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_pkt", pkt_done, 1'b0);
    rst_n = 1'b1;
    write = 1'b1; send = 1'b1; wdata = word_of(0);
    tick();
    write = 1'b0; send = 1'b0;
    chk("t1_level_after_wr", level, 5'd1);
    chk("t1_empty_lag", empty, 1'b1);
    tick();
    chk("t1_empty", empty, 1'b0);
    chk("t1_lane0", rdata, 64'h1);
    read = 1'b1;
    tick();
    chk("t1_lane1", rdata, 64'h2);
    tick();
    chk("t1_lane2", rdata, 64'h3);
    tick();
    chk("t1_lane3", rdata, 64'h4);
    chk("t1_nopkt_yet", pkt_done, 1'b0);
    tick();
    read = 1'b0;
    chk("t1_pkt", pkt_done, 1'b1);
    chk("t1_empty_end", empty, 1'b1);
    chk("t1_level_end", level, 5'd0);
    tick();
    chk("t1_pkt_pulse", pkt_done, 1'b0);

    // 2: fill to full, overflow on 17th, drain in order
    fill16();
    chk("t2_full", full, 1'b1);
    chk("t2_level", level, 5'd16);
    chk("t2_ovf0", overflow, 1'b0);
    write = 1'b1; wdata = word_of(99);
    tick();
    write = 1'b0;
    chk("t2_ovf", overflow, 1'b1);
    chk("t2_level17", level, 5'd16);
    for (int i = 0; i < 64; i++) begin
      chk("t2_drain", rdata, lane_of(i / 4, i % 4));
      read = 1'b1;
      tick();
    end
    read = 1'b0;
    chk("t2_empty", empty, 1'b1);
    chk("t2_level0", level, 5'd0);

    // 3: reads while empty are ignored
    hold = rdata;
    chk("t3_hold_val", hold, lane_of(15, 3));
    read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_data", rdata, hold);
      chk("t3_level", level, 5'd0);
      chk("t3_pkt", pkt_done, 1'b0);
    end
    read = 1'b0;

    // 4: write + lane-3 pop on a full buffer: write dropped, then accepted
    do_reset();
    fill16();
    read = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_lane3", rdata, lane_of(0, 3));
    write = 1'b1; wdata = word_of(50);
    tick();
    write = 1'b0; read = 1'b0;
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_level15", level, 5'd15);
    chk("t4_notfull", full, 1'b0);
    chk("t4_next_head", rdata, lane_of(1, 0));
    write = 1'b1; wdata = word_of(51);
    tick();
    write = 1'b0;
    chk("t4_level16", level, 5'd16);
    chk("t4_full", full, 1'b1);

    // 5: streaming, one write every 4 cycles, read whenever data is shown
    do_reset();
    widx = 0; exp_pkts = 0; got_pkts = 0; saw_full = 0;
    for (int c = 0; c < 700 && (widx < 100 || q.size() != 0); c++) begin
      if (pkt_done) got_pkts++;
      if (full) saw_full = 1;
      if (!empty) begin
        if (q.size() == 0) begin
          chk("t5_extra", 1'b1, 1'b0);
          read = 1'b0;
        end else begin
          chk("t5_data", rdata, q[0]);
          void'(q.pop_front());
          read = 1'b1;
        end
      end else begin
        read = 1'b0;
      end
      if ((c % 4) == 0 && widx < 100) begin
        write = 1'b1;
        wdata = word_of(widx + 100);
        send = ((widx % 3) == 2);
        if (send) exp_pkts++;
        for (int j = 0; j < 4; j++) q.push_back(lane_of(widx + 100, j));
        widx++;
      end else begin
        write = 1'b0; send = 1'b0;
      end
      tick();
    end
    if (pkt_done) got_pkts++;
    read = 1'b0; write = 1'b0; send = 1'b0;
    chk("t5_all_read", 256'(q.size()), 256'd0);
    chk("t5_all_written", 256'(widx), 256'd100);
    chk("t5_never_full", saw_full, 1'b0);
    chk("t5_pkts", 256'(got_pkts), 256'(exp_pkts));
    chk("t5_empty", empty, 1'b1);

    // 6: reset in the middle of a packet discards everything
    do_reset();
    for (int k = 0; k < 3; k++) begin
      write = 1'b1; send = (k == 2); wdata = word_of(k + 20);
      tick();
    end
    write = 1'b0; send = 1'b0;
    read = 1'b1;
    tick();
    tick();
    read = 1'b0;
    chk("t6_mid", rdata, lane_of(20, 2));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_empty", empty, 1'b1);
    chk("t6_level", level, 5'd0);
    chk("t6_ovf", overflow, 1'b0);
    chk("t6_data", rdata, 64'h0);
    write = 1'b1; wdata = word_of(7);
    tick();
    write = 1'b0;
    tick();
    chk("t6_fresh_empty", empty, 1'b0);
    chk("t6_fresh_lane0", rdata, lane_of(7, 0));
    chk("t6_fresh_level", level, 5'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
